// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory address, registers the
// returned word into ir_out and handles decode-stage redirects.
// IDLE spends one cycle after reset. RUN fetches and stalls. FLUSH covers the one dead cycle
// that follows a redirect.
// Optional build macro FETCH_PERF_CNT_EN adds a wrapping load counter on fetch_cnt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_n_in,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  output logic [31:0] ir_out,
  output logic [31:0] ir_pc_n,
  output logic        ir_valid,
  input  logic        ir_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        redirect;
  logic        load;
  logic [31:0] br_target;

  // Redirect wins over both load and stall; a branch only counts against a valid IR in RUN.
  always_comb begin
    redirect  = (state_q == RUN) && ir_valid && br_taken;
    load      = (state_q == RUN) && !redirect && (!ir_valid || ir_ready);
    br_target = ir_pc_n + {{16{br_offset[15]}}, br_offset};
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = redirect ? FLUSH : RUN;
      FLUSH:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and instruction register. A redirect updates the PC and drops the IR contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out   <= RESET_PC;
      ir_out   <= 32'd0;
      ir_pc_n  <= 32'd0;
      ir_valid <= 1'b0;
    end else if (redirect) begin
      pc_out   <= br_target;
      ir_valid <= 1'b0;
    end else if (load) begin
      pc_out   <= pc_n_in;
      ir_out   <= inst_in;
      ir_pc_n  <= pc_n_in;
      ir_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counts every IR load and wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
    end else if (load) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a combinational instruction-memory model.
// It checks the expected instruction stream against a queue that the tests fill.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] inst_in;
  logic [31:0] pc_n_in;
  logic        br_taken;
  logic [15:0] br_offset;
  logic [31:0] ir_out;
  logic [31:0] ir_pc_n;
  logic        ir_valid;
  logic        ir_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];  // {ir_pc_n, ir_out}
  logic [63:0] e;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_out   (pc_out),
    .inst_in  (inst_in),
    .pc_n_in  (pc_n_in),
    .br_taken (br_taken),
    .br_offset(br_offset),
    .ir_out   (ir_out),
    .ir_pc_n  (ir_pc_n),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt)
`endif
  );

  // Memory model: beq, sub, add, add at 0..3, address-derived filler elsewhere.
  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'd0:   word = 32'h10010002;
      32'd1:   word = 32'h00430822;
      32'd2:   word = 32'h00a42020;
      32'd3:   word = 32'h00851020;
      default: word = {16'hc0de, a[15:0]} ^ {a[31:16], 16'h0000};
    endcase
  endfunction

  assign inst_in = word(pc_out);
  assign pc_n_in = pc_out + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, IDLE cycle, first RUN cycle; returns just after the first load edge.
  task automatic apply_reset();
    rst = 1'b1; ir_ready = 1'b1; br_taken = 1'b0; br_offset = 16'd0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ir_ready = 1'b1; br_taken = 1'b0; br_offset = 16'd0;
    exp_q.delete();
    tick();
    checks++;
    if (pc_out !== 32'd0 || ir_valid !== 1'b0 || ir_out !== 32'd0 || ir_pc_n !== 32'd0) begin
      errors++;
      $display("FAIL reset_values pc=%h v=%b ir=%h pcn=%h exp 0/0/0/0",
               pc_out, ir_valid, ir_out, ir_pc_n);
    end
    rst = 1'b0;
    exp_q.push_back({32'd1, 32'h10010002});
    tick();
    checks++;
    if (pc_out !== 32'd0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle pc=%h v=%b exp pc=0 v=0", pc_out, ir_valid);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ir_pc_n, ir_out} !== e || pc_out !== 32'd1 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_load ir=%h pcn=%h pc=%h v=%b exp ir=%h pcn=%h pc=1 v=1",
               ir_out, ir_pc_n, pc_out, ir_valid, e[31:0], e[63:32]);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ir_out !== 32'h10010002 || ir_pc_n !== 32'd1 || pc_out !== 32'd1 || ir_valid !== 1'b1)
      begin
        errors++;
        $display("FAIL stall_hold%0d ir=%h pcn=%h pc=%h v=%b exp 10010002/1/1/1",
                 i, ir_out, ir_pc_n, pc_out, ir_valid);
      end
    end
    ir_ready = 1'b1;
    exp_q.push_back({32'd2, word(32'd1)});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ir_pc_n, ir_out} !== e || pc_out !== 32'd2) begin
      errors++;
      $display("FAIL stall_release ir=%h pcn=%h pc=%h exp ir=%h pcn=%h pc=2",
               ir_out, ir_pc_n, pc_out, e[31:0], e[63:32]);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    br_taken = 1'b1; br_offset = 16'd2;
    exp_q.push_back({32'd4, 32'h00851020});
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc_out !== 32'd3 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_redirect pc=%h v=%b exp pc=3 v=0", pc_out, ir_valid);
    end
    tick();
    checks++;
    if (pc_out !== 32'd3 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_flush pc=%h v=%b exp pc=3 v=0", pc_out, ir_valid);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ir_pc_n, ir_out} !== e || ir_valid !== 1'b1 || pc_out !== 32'd4) begin
      errors++;
      $display("FAIL branch_target ir=%h pcn=%h v=%b pc=%h exp ir=%h pcn=%h v=1 pc=4",
               ir_out, ir_pc_n, ir_valid, pc_out, e[31:0], e[63:32]);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    ir_ready = 1'b0; br_taken = 1'b1; br_offset = 16'd1;
    tick();
    checks++;
    if (pc_out !== 32'd2 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_redirect pc=%h v=%b exp pc=2 v=0", pc_out, ir_valid);
    end
    br_offset = 16'd5;  // still asserted during FLUSH, must be ignored
    tick();
    br_taken = 1'b0; ir_ready = 1'b1;
    checks++;
    if (pc_out !== 32'd2 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_flush_ignore pc=%h v=%b exp pc=2 v=0", pc_out, ir_valid);
    end
    exp_q.push_back({32'd3, word(32'd2)});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ir_pc_n, ir_out} !== e || pc_out !== 32'd3) begin
      errors++;
      $display("FAIL prio_target ir=%h pcn=%h pc=%h exp ir=%h pcn=%h pc=3",
               ir_out, ir_pc_n, pc_out, e[31:0], e[63:32]);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    br_taken = 1'b1; br_offset = 16'hfffe;  // 1 - 2
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc_out !== 32'hffffffff) begin
      errors++;
      $display("FAIL wrap_neg_branch pc=%h exp ffffffff", pc_out);
    end
    tick();
    exp_q.push_back({32'd0, word(32'hffffffff)});
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({ir_pc_n, ir_out} !== e || pc_out !== 32'd0) begin
      errors++;
      $display("FAIL wrap_pc_inc ir=%h pcn=%h pc=%h exp ir=%h pcn=%h pc=0",
               ir_out, ir_pc_n, pc_out, e[31:0], e[63:32]);
    end
    br_taken = 1'b1; br_offset = 16'hffff;  // 0 - 1
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc_out !== 32'hffffffff || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_zero_minus_one pc=%h v=%b exp ffffffff v=0", pc_out, ir_valid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (pc_out !== 32'd5 || ir_pc_n !== 32'd5) begin
      errors++;
      $display("FAIL five_loads pc=%h pcn=%h exp 5/5", pc_out, ir_pc_n);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fetch_cnt !== 32'd5) begin
      errors++;
      $display("FAIL cnt_before cnt=%0d exp 5", fetch_cnt);
    end
`endif
    br_taken = 1'b1; br_offset = 16'd3;
    tick();
    br_taken = 1'b0;
    checks++;
    if (pc_out !== 32'd8 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_redirect pc=%h v=%b exp 8/0", pc_out, ir_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc_out !== 32'd0 || ir_valid !== 1'b0 || ir_out !== 32'd0 || ir_pc_n !== 32'd0) begin
      errors++;
      $display("FAIL async_reset pc=%h v=%b ir=%h pcn=%h exp 0/0/0/0",
               pc_out, ir_valid, ir_out, ir_pc_n);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fetch_cnt !== 32'd0) begin
      errors++;
      $display("FAIL cnt_after cnt=%0d exp 0", fetch_cnt);
    end
`endif
    // Restart must show no trace of the pending redirect.
    apply_reset();
    exp_q.push_back({32'd1, 32'h10010002});
    e = exp_q.pop_front();
    checks++;
    if ({ir_pc_n, ir_out} !== e || pc_out !== 32'd1 || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_restart ir=%h pcn=%h pc=%h v=%b exp ir=%h pcn=%h pc=1 v=1",
               ir_out, ir_pc_n, pc_out, ir_valid, e[31:0], e[63:32]);
    end
  endtask

  initial begin
    rst = 1'b1; ir_ready = 1'b1; br_taken = 1'b0; br_offset = 16'd0;
    test_reset();
    test_stall();
    test_branch();
    test_priority();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound in case the clock or a task stalls.
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
